// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and default geometry for the matrix BRAM port-A arbiter.
// Imported by the arbiter top, its interface and the round-robin picker.
package bram_port_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH = 12;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_REQ_IDX_W = req_idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM port-A bundle; the arbiter is the slave, the environment the master.
// bound_err exists only when BRAM_ARB_BOUNDS_EN is defined.
interface bram_port_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 12
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_din;
    logic [DATA_WIDTH-1:0]         mem_dout;
    logic                          busy;
    logic                          lock_err;
`ifdef BRAM_ARB_BOUNDS_EN
    logic                          bound_err;
`endif

    modport slave (
        input  req, we, lock, addr, wdata, mem_dout,
`ifdef BRAM_ARB_BOUNDS_EN
        output bound_err,
`endif
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_din, busy, lock_err
    );

    modport master (
        output req, we, lock, addr, wdata, mem_dout,
`ifdef BRAM_ARB_BOUNDS_EN
        input  bound_err,
`endif
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_din, busy, lock_err
    );

endinterface

// File: rtl/bram_port_arbiter_rr_priority_picker.sv
// Round-robin picker: first asserted req at or above ptr, wrapping around.
// Latency: combinational. Backpressure: none, pure selection logic.
// Returns a one-hot grant, the winning index and an any-winner flag.
module rr_priority_picker
    import bram_port_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = req_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = j;
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with owner lock sharing matrix BRAM port A; macro BRAM_ARB_BOUNDS_EN adds address bounds.
// Latency: gnt combinational in N, mem_* registered in N+1, rvalid/rdata in N+2.
// Backpressure: requesters hold req until gnt; one access per cycle, lock stalls all non-owners.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LOCK_TIMEOUT = 64,
    parameter int ADDR_LIMIT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    bram_port_arbiter_if.slave bus
);

    localparam int IW = req_idx_w(NUM_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t             state;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          owner;
    logic [CW-1:0]          tmo_cnt;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;

    logic [NUM_REQ-1:0]     gnt_w;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_any;

    logic                   sel_we;
    logic                   sel_lock;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_din;
    logic                   illegal;

    logic                   mem_en_q, mem_we_q, lock_err_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [DATA_WIDTH-1:0]  mem_din_q;

    // Two-stage read tag so rvalid lines up with BRAM output data.
    logic                   rd_vld1, rd_vld2, rd_zero1, rd_zero2;
    logic [IW-1:0]          rd_idx1, rd_idx2;
    logic [NUM_REQ-1:0]     rvalid_w;

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_priority_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        gnt_w   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (state == ARB) begin
            gnt_w   = pick_gnt;
            gnt_idx = pick_idx;
            gnt_any = pick_any;
        end else begin
            gnt_any = bus.req[owner];
            gnt_idx = owner;
            gnt_w   = gnt_any ? (NUM_REQ'(1) << owner) : '0;
        end
    end

    assign sel_we   = bus.we[gnt_idx];
    assign sel_lock = bus.lock[gnt_idx];
    assign sel_addr = bus.addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_din  = bus.wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef BRAM_ARB_BOUNDS_EN
    logic bound_err_q;
    assign illegal       = gnt_any && (32'(sel_addr) >= 32'(ADDR_LIMIT));
    assign bus.bound_err = bound_err_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            ptr        <= '0;
            owner      <= '0;
            tmo_cnt    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            lock_err_q <= 1'b0;
            rd_vld1    <= 1'b0;
            rd_vld2    <= 1'b0;
            rd_zero1   <= 1'b0;
            rd_zero2   <= 1'b0;
            rd_idx1    <= '0;
            rd_idx2    <= '0;
`ifdef BRAM_ARB_BOUNDS_EN
            bound_err_q <= 1'b0;
`endif
        end else begin
            lock_err_q <= 1'b0;
            mem_en_q   <= gnt_any && !illegal;
            mem_we_q   <= gnt_any && sel_we && !illegal;
            if (gnt_any && !illegal) begin
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_din;
            end
            rd_vld1  <= gnt_any && !sel_we;
            rd_idx1  <= gnt_idx;
            rd_zero1 <= illegal;
            rd_vld2  <= rd_vld1;
            rd_idx2  <= rd_idx1;
            rd_zero2 <= rd_zero1;
`ifdef BRAM_ARB_BOUNDS_EN
            bound_err_q <= illegal;
`endif
            if (gnt_any)
                ptr <= ptr_after(gnt_idx);

            case (state)
                ARB: begin
                    if (gnt_any && sel_lock) begin
                        state   <= LOCKED;
                        owner   <= gnt_idx;
                        tmo_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // An owner access on the limit cycle wins over the timeout.
                    if (gnt_any) begin
                        tmo_cnt <= '0;
                        if (!sel_lock)
                            state <= ARB;
                    end else if (tmo_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state      <= ARB;
                        tmo_cnt    <= '0;
                        lock_err_q <= 1'b1;
                        ptr        <= ptr_after(owner);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_comb begin
        rvalid_w = '0;
        if (rd_vld2)
            rvalid_w[rd_idx2] = 1'b1;
    end

    assign bus.gnt      = gnt_w;
    assign bus.rvalid   = rvalid_w;
    assign bus.rdata    = rd_zero2 ? '0 : bus.mem_dout;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.busy     = (state == LOCKED);
    assign bus.lock_err = lock_err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural read-first BRAM on port A.
// Inputs change 1ns after posedge; outputs are checked on the following negedge.
module tb_bram_port_arbiter;
    localparam int NR = 3;
    localparam int DW = 4;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    bram_port_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_port_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .LOCK_TIMEOUT(4), .ADDR_LIMIT(12'h800)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                mem[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[i]            = w;
        bus.lock[i]          = l;
        bus.addr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        mem[12'h010] = 4'h7;
        mem[12'h020] = 4'h3;
        mem[12'h021] = 4'h9;
        mem[12'h022] = 4'hC;
        rst = 1'b1;
        bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
        bus.mem_dout = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lock_err", bus.lock_err, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_gnt", bus.gnt, 0);

        // Single read by requester 1
        cyc(); rst = 1'b0;
        bus.req = 3'b010; set_req(1, 0, 0, 12'h010, 0);
        @(negedge clk); chk("rd_gnt", bus.gnt, 3'b010);
        cyc(); bus.req = '0;
        @(negedge clk);
        chk("rd_mem_en", bus.mem_en, 1);
        chk("rd_mem_we", bus.mem_we, 0);
        chk("rd_mem_addr", bus.mem_addr, 12'h010);
        chk("rd_rvalid_early", bus.rvalid, 0);
        cyc(); @(negedge clk);
        chk("rd_rvalid", bus.rvalid, 3'b010);
        chk("rd_rdata", bus.rdata, 4'h7);
        cyc(); @(negedge clk);
        chk("rd_rvalid_done", bus.rvalid, 0);
        chk("idle_mem_en", bus.mem_en, 0);

        // Write by requester 2 (pointer 2 -> 0 afterwards)
        cyc(); bus.req = 3'b100; set_req(2, 1, 0, 12'h030, 4'hA);
        @(negedge clk); chk("wr_gnt", bus.gnt, 3'b100);
        cyc(); bus.req = '0;
        @(negedge clk);
        chk("wr_mem_we", bus.mem_we, 1);
        chk("wr_mem_addr", bus.mem_addr, 12'h030);
        chk("wr_mem_din", bus.mem_din, 4'hA);
        cyc(); @(negedge clk);
        chk("wr_no_rvalid", bus.rvalid, 0);

        // Round robin with all three reading
        cyc(); bus.req = 3'b111; bus.we = '0; bus.lock = '0;
        set_req(0, 0, 0, 12'h020, 0); set_req(1, 0, 0, 12'h021, 0); set_req(2, 0, 0, 12'h022, 0);
        @(negedge clk); chk("rr_gnt0", bus.gnt, 3'b001);
        cyc(); @(negedge clk);
        chk("rr_gnt1", bus.gnt, 3'b010);
        chk("rr_addr0", bus.mem_addr, 12'h020);
        cyc(); @(negedge clk);
        chk("rr_gnt2", bus.gnt, 3'b100);
        chk("rr_rvalid0", bus.rvalid, 3'b001);
        chk("rr_rdata0", bus.rdata, 4'h3);
        cyc(); @(negedge clk);
        chk("rr_gnt0b", bus.gnt, 3'b001);
        chk("rr_rvalid1", bus.rvalid, 3'b010);
        chk("rr_rdata1", bus.rdata, 4'h9);
        cyc(); bus.req = '0;
        @(negedge clk);
        chk("rr_gnt_none", bus.gnt, 0);
        chk("rr_rvalid2", bus.rvalid, 3'b100);
        chk("rr_rdata2", bus.rdata, 4'hC);
        cyc(); @(negedge clk);
        chk("rr_rvalid0b", bus.rvalid, 3'b001);
        chk("rr_rdata0b", bus.rdata, 4'h3);
        cyc(); @(negedge clk);
        chk("hold_mem_en", bus.mem_en, 0);
        chk("hold_mem_addr", bus.mem_addr, 12'h020);

        // Lock sequence by requester 2 while requester 0 waits (pointer at 1)
        cyc(); bus.req = 3'b101; set_req(0, 0, 0, 12'h020, 0); set_req(2, 1, 1, 12'h100, 4'h1);
        @(negedge clk);
        chk("lk_gnt_a", bus.gnt, 3'b100);
        chk("lk_busy_a", bus.busy, 0);
        cyc(); set_req(2, 1, 1, 12'h101, 4'h2);
        @(negedge clk);
        chk("lk_gnt_b", bus.gnt, 3'b100);
        chk("lk_busy_b", bus.busy, 1);
        chk("lk_mem_addr_a", bus.mem_addr, 12'h100);
        chk("lk_mem_din_a", bus.mem_din, 4'h1);
        cyc(); set_req(2, 1, 1, 12'h102, 4'h3);
        @(negedge clk);
        chk("lk_gnt_c", bus.gnt, 3'b100);
        chk("lk_busy_c", bus.busy, 1);
        cyc(); set_req(2, 1, 0, 12'h103, 4'h4);
        @(negedge clk);
        chk("lk_gnt_d", bus.gnt, 3'b100);
        chk("lk_busy_d", bus.busy, 1);
        cyc(); bus.req = 3'b001;
        @(negedge clk);
        chk("lk_gnt_after", bus.gnt, 3'b001);
        chk("lk_busy_after", bus.busy, 0);
        chk("lk_mem_addr_d", bus.mem_addr, 12'h103);
        chk("lk_mem_din_d", bus.mem_din, 4'h4);
        cyc(); bus.req = '0;
        @(negedge clk); chk("lk_mem_we_0", bus.mem_we, 0);
        cyc(); @(negedge clk);
        chk("lk_rvalid_0", bus.rvalid, 3'b001);
        chk("lk_rdata_0", bus.rdata, 4'h3);

        // Lock timeout: owner 1 locks then drops req, requester 2 pending (pointer at 1)
        cyc(); bus.req = 3'b010; set_req(1, 0, 1, 12'h010, 0); set_req(2, 0, 0, 12'h022, 0);
        @(negedge clk); chk("to_gnt_lock", bus.gnt, 3'b010);
        cyc(); bus.req = 3'b100; set_req(1, 0, 0, 12'h010, 0);
        @(negedge clk);
        chk("to_gnt_blocked1", bus.gnt, 0);
        chk("to_busy1", bus.busy, 1);
        cyc(); @(negedge clk);
        chk("to_gnt_blocked2", bus.gnt, 0);
        chk("to_owner_rvalid", bus.rvalid, 3'b010);
        chk("to_owner_rdata", bus.rdata, 4'h7);
        cyc(); @(negedge clk);
        chk("to_lock_err_early3", bus.lock_err, 0);
        cyc(); @(negedge clk);
        chk("to_lock_err_early4", bus.lock_err, 0);
        chk("to_busy4", bus.busy, 1);
        cyc(); @(negedge clk);
        chk("to_lock_err", bus.lock_err, 1);
        chk("to_busy_clear", bus.busy, 0);
        chk("to_gnt_pending", bus.gnt, 3'b100);
        cyc(); bus.req = '0;
        @(negedge clk); chk("to_lock_err_pulse", bus.lock_err, 0);

        // Owner grant on the limit cycle beats the timeout (pointer at 0)
        cyc(); bus.req = 3'b001; set_req(0, 0, 1, 12'h020, 0);
        @(negedge clk); chk("lim_gnt_lock", bus.gnt, 3'b001);
        cyc(); bus.req = '0;
        cyc(); cyc(); cyc(); bus.req = 3'b001;
        @(negedge clk); chk("lim_gnt_owner", bus.gnt, 3'b001);
        cyc(); set_req(0, 0, 0, 12'h020, 0);
        @(negedge clk);
        chk("lim_no_lock_err", bus.lock_err, 0);
        chk("lim_busy", bus.busy, 1);
        chk("lim_gnt_unlock", bus.gnt, 3'b001);
        cyc(); bus.req = '0;
        @(negedge clk);
        chk("lim_busy_clear", bus.busy, 0);
        chk("lim_lock_err_none", bus.lock_err, 0);

        // Reset while a locking read is in flight (pointer at 1)
        cyc(); cyc(); bus.req = 3'b010; set_req(1, 0, 1, 12'h010, 0);
        @(negedge clk); chk("rr_mid_gnt", bus.gnt, 3'b010);
        cyc(); bus.req = '0; rst = 1'b1;
        @(negedge clk); chk("rr_mid_mem_en", bus.mem_en, 1);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid", bus.rvalid, 0);
        chk("rstmid_mem_en", bus.mem_en, 0);
        chk("rstmid_mem_addr", bus.mem_addr, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_lock_err", bus.lock_err, 0);
        cyc(); @(negedge clk);
        chk("rstmid_rvalid_late", bus.rvalid, 0);

`ifdef BRAM_ARB_BOUNDS_EN
        // Out-of-range write then read by requester 0 (pointer at 0 after reset)
        cyc(); bus.req = 3'b001; set_req(0, 1, 0, 12'h900, 4'h5);
        @(negedge clk); chk("bnd_wr_gnt", bus.gnt, 3'b001);
        cyc(); set_req(0, 0, 0, 12'h900, 0);
        @(negedge clk);
        chk("bnd_wr_mem_en", bus.mem_en, 0);
        chk("bnd_wr_err", bus.bound_err, 1);
        chk("bnd_rd_gnt", bus.gnt, 3'b001);
        cyc(); bus.req = '0;
        @(negedge clk);
        chk("bnd_rd_mem_en", bus.mem_en, 0);
        chk("bnd_rd_err", bus.bound_err, 1);
        cyc(); @(negedge clk);
        chk("bnd_rd_rvalid", bus.rvalid, 3'b001);
        chk("bnd_rd_rdata", bus.rdata, 0);
        chk("bnd_err_clear", bus.bound_err, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
